// File: rtl/microcode_sequencer.sv
// Microcode sequencer: owns the micro-step counter and latched opcode, addresses the
// microcode ROM as {opcode, step} and gates the returned microword onto the control bus.
module microcode_sequencer #(
    parameter int FETCH_STEPS = 4,
    parameter int MAX_STEPS   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic        halt_req,
    input  logic        stall,
    input  logic [7:0]  ir_opcode,
    input  logic [31:0] ucode_data,
    output logic [15:0] ucode_addr,
    output logic [31:0] ctrl_word,
    output logic        instr_done,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, FAULT} state_t;

    localparam logic [7:0] LAST_FETCH = 8'(FETCH_STEPS - 1);
    localparam logic [7:0] FIRST_EXEC = 8'(FETCH_STEPS);
    localparam logic [7:0] LAST_STEP  = 8'(MAX_STEPS - 1);

    state_t     state_q, state_d;
    logic [7:0] step_q, step_d;
    logic [7:0] opcode_q, opcode_d;
    logic       busy_q, busy_d;
    logic       fault_q, fault_d;

    logic wordZero;
    logic active;

    assign wordZero   = (ucode_data == 32'h0);
    assign active     = ((state_q == FETCH) || (state_q == EXEC)) && !stall;
    assign ctrl_word  = active ? ucode_data : 32'h0;
    assign instr_done = (state_q == EXEC) && !stall && wordZero;
    assign ucode_addr = {opcode_q, step_q};
    assign busy       = busy_q;
    assign fault      = fault_q;

    // A zero word marks the end of an instruction in EXEC but is malformed in FETCH.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        opcode_d = opcode_q;
        case (state_q)
            IDLE: begin
                step_d = 8'h0;
                if (run && !halt_req) state_d = FETCH;
            end
            FETCH: begin
                if (!stall) begin
                    if (wordZero) begin
                        state_d = FAULT;
                    end else if (step_q == LAST_FETCH) begin
                        opcode_d = ir_opcode;
                        step_d   = FIRST_EXEC;
                        state_d  = EXEC;
                    end else begin
                        step_d = step_q + 8'd1;
                    end
                end
            end
            EXEC: begin
                if (!stall) begin
                    if (wordZero) begin
                        step_d  = 8'h0;
                        state_d = (halt_req || !run) ? IDLE : FETCH;
                    end else if (step_q == LAST_STEP) begin
                        state_d = FAULT;
                    end else begin
                        step_d = step_q + 8'd1;
                    end
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d == FETCH) || (state_d == EXEC);
        fault_d = (state_d == FAULT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            step_q   <= 8'h0;
            opcode_q <= 8'h0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            opcode_q <= opcode_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
        end
    end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Testbench for microcode_sequencer: a small ROM model feeds the DUT, and expected
// per-cycle outputs are queued at drive time and checked on the falling edge.
module tb_microcode_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic        halt_req;
    logic        stall;
    logic [7:0]  ir_opcode;
    logic [31:0] ucode_data;
    logic [15:0] ucode_addr;
    logic [31:0] ctrl_word;
    logic        instr_done;
    logic        busy;
    logic        fault;

    typedef struct {
        string       tag;
        logic [15:0] addr;
        logic [31:0] ctrl;
        logic        done;
        logic        busy;
        logic        fault;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   nTests = 0;
    int   nFail  = 0;

    always #5 clk = ~clk;

    microcode_sequencer #(.FETCH_STEPS(4), .MAX_STEPS(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .halt_req   (halt_req),
        .stall      (stall),
        .ir_opcode  (ir_opcode),
        .ucode_data (ucode_data),
        .ucode_addr (ucode_addr),
        .ctrl_word  (ctrl_word),
        .instr_done (instr_done),
        .busy       (busy),
        .fault      (fault)
    );

    // ROM contents: identical fetch words on every page, then per-opcode execute words.
    function automatic logic [31:0] rom(input logic [15:0] a);
        logic [7:0] op;
        logic [7:0] st;
        op = a[15:8];
        st = a[7:0];
        if (st < 8'd4) return 32'hA500_0000 | {24'h0, st};
        case (op)
            8'h00: begin
                if (st == 8'd4) return 32'h1111_0004;
                if (st == 8'd5) return 32'h1111_0005;
                return 32'h0;
            end
            8'h01: begin
                if (st == 8'd4) return 32'h2222_0004;
                if (st == 8'd5) return 32'h2222_0005;
                return 32'h0;
            end
            8'h02:   return (st == 8'd4) ? 32'h8842_004A : 32'h0;
            8'h03:   return 32'h3333_0000 | {24'h0, st};
            default: return 32'h0;
        endcase
    endfunction

    assign ucode_data = rom(ucode_addr);

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        nTests++;
        if (obs !== expv) begin
            nFail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic rn, input logic r, input logic h,
                                 input logic s, input logic [7:0] op, input bit chk,
                                 input logic [15:0] ea, input logic [31:0] ec,
                                 input logic ed, input logic eb, input logic ef);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = rn;
        run       = r;
        halt_req  = h;
        stall     = s;
        ir_opcode = op;
        if (chk) begin
            e.tag   = tag;
            e.addr  = ea;
            e.ctrl  = ec;
            e.done  = ed;
            e.busy  = eb;
            e.fault = ef;
            expQ.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (expQ.size() != 0) begin
            monE = expQ.pop_front();
            checkOutput({monE.tag, " addr"},  {16'h0, ucode_addr}, {16'h0, monE.addr});
            checkOutput({monE.tag, " ctrl"},  ctrl_word,           monE.ctrl);
            checkOutput({monE.tag, " done"},  {31'h0, instr_done}, {31'h0, monE.done});
            checkOutput({monE.tag, " busy"},  {31'h0, busy},       {31'h0, monE.busy});
            checkOutput({monE.tag, " fault"}, {31'h0, fault},      {31'h0, monE.fault});
        end
    end

    initial begin
        logic [15:0] a;
        rst_n = 1'b0; run = 1'b1; halt_req = 1'b0; stall = 1'b0; ir_opcode = 8'h5A;

        applyStimulus("rst_hold", 0, 1, 0, 0, 8'h5A, 0, 16'h0, 32'h0, 0, 0, 0);
        applyStimulus("rst",      0, 1, 0, 0, 8'h5A, 1, 16'h0000, 32'h0, 0, 0, 0);
        applyStimulus("idle",     1, 0, 0, 0, 8'h00, 1, 16'h0000, 32'h0, 0, 0, 0);

        // LDA, followed back-to-back by ADD
        applyStimulus("lda_go",   1, 1, 0, 0, 8'h00, 1, 16'h0000, 32'h0, 0, 0, 0);
        for (int s = 0; s < 6; s++) begin
            a = {8'h00, 8'(s)};
            applyStimulus("lda_step", 1, 1, 0, 0, 8'h00, 1, a, rom(a), 0, 1, 0);
        end
        applyStimulus("lda_done", 1, 1, 0, 0, 8'h02, 1, 16'h0006, 32'h0, 1, 1, 0);
        for (int s = 0; s < 4; s++) begin
            a = {8'h00, 8'(s)};
            applyStimulus("add_fetch", 1, 1, 0, 0, 8'h02, 1, a, rom(a), 0, 1, 0);
        end
        for (int i = 0; i < 3; i++)
            applyStimulus("add_stall", 1, 1, 0, 1, 8'h02, 1, 16'h0204, 32'h0, 0, 1, 0);
        applyStimulus("add_exec", 1, 1, 0, 0, 8'h02, 1, 16'h0204, 32'h8842_004A, 0, 1, 0);
        applyStimulus("add_done", 1, 0, 0, 0, 8'h02, 1, 16'h0205, 32'h0, 1, 1, 0);
        applyStimulus("add_idle", 1, 0, 0, 0, 8'h02, 1, 16'h0200, 32'h0, 0, 0, 0);

        // Undefined opcode runs as a NOP; stall on the end marker delays instr_done
        applyStimulus("nop_go", 1, 1, 0, 0, 8'h07, 1, 16'h0200, 32'h0, 0, 0, 0);
        for (int s = 0; s < 4; s++) begin
            a = {8'h02, 8'(s)};
            applyStimulus("nop_fetch", 1, 1, 0, 0, 8'h07, 1, a, rom(a), 0, 1, 0);
        end
        applyStimulus("nop_stall", 1, 1, 0, 1, 8'h07, 1, 16'h0704, 32'h0, 0, 1, 0);
        applyStimulus("nop_done",  1, 0, 0, 0, 8'h07, 1, 16'h0704, 32'h0, 1, 1, 0);
        applyStimulus("nop_idle",  1, 0, 0, 0, 8'h07, 1, 16'h0700, 32'h0, 0, 0, 0);

        // Halt requested mid-fetch of LDB must not truncate it
        applyStimulus("ldb_go", 1, 1, 0, 0, 8'h01, 1, 16'h0700, 32'h0, 0, 0, 0);
        for (int s = 0; s < 4; s++) begin
            a = {8'h07, 8'(s)};
            applyStimulus("ldb_fetch", 1, 1, (s >= 2), 0, 8'h01, 1, a, rom(a), 0, 1, 0);
        end
        for (int s = 4; s < 6; s++) begin
            a = {8'h01, 8'(s)};
            applyStimulus("ldb_exec", 1, 1, 1, 0, 8'h01, 1, a, rom(a), 0, 1, 0);
        end
        applyStimulus("ldb_done", 1, 1, 1, 0, 8'h01, 1, 16'h0106, 32'h0, 1, 1, 0);
        for (int i = 0; i < 3; i++)
            applyStimulus("halt_idle", 1, 1, 1, 0, 8'h03, 1, 16'h0100, 32'h0, 0, 0, 0);
        applyStimulus("halt_rel", 1, 1, 0, 0, 8'h03, 1, 16'h0100, 32'h0, 0, 0, 0);

        // Runaway: opcode 03 never produces an end marker
        for (int s = 0; s < 4; s++) begin
            a = {8'h01, 8'(s)};
            applyStimulus("run_fetch", 1, 1, 0, 0, 8'h03, 1, a, rom(a), 0, 1, 0);
        end
        for (int s = 4; s < 16; s++) begin
            a = {8'h03, 8'(s)};
            applyStimulus("run_exec", 1, 1, 0, 0, 8'h03, 1, a, rom(a), 0, 1, 0);
        end
        for (int i = 0; i < 2; i++)
            applyStimulus("run_fault", 1, 1, 0, 0, 8'h03, 1, 16'h030F, 32'h0, 0, 0, 1);
        applyStimulus("run_rst", 0, 1, 0, 0, 8'h03, 1, 16'h030F, 32'h0, 0, 0, 1);
        applyStimulus("run_clr", 1, 0, 0, 0, 8'h00, 1, 16'h0000, 32'h0, 0, 0, 0);

        // Reset asserted in the middle of EXEC
        applyStimulus("mid_go", 1, 1, 0, 0, 8'h00, 1, 16'h0000, 32'h0, 0, 0, 0);
        for (int s = 0; s < 4; s++) begin
            a = {8'h00, 8'(s)};
            applyStimulus("mid_fetch", 1, 1, 0, 0, 8'h00, 1, a, rom(a), 0, 1, 0);
        end
        applyStimulus("mid_exec", 0, 1, 0, 0, 8'h00, 1, 16'h0004, 32'h1111_0004, 0, 1, 0);
        applyStimulus("mid_rst",  1, 0, 0, 0, 8'h00, 1, 16'h0000, 32'h0, 0, 0, 0);
        applyStimulus("mid_idle", 1, 0, 0, 0, 8'h00, 1, 16'h0000, 32'h0, 0, 0, 0);

        @(negedge clk);
        @(posedge clk);
        checkOutput("drain", expQ.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
